// File: rtl/jt900h_intctl.sv
// Memory-mapped interrupt source for the jt900h bus: programmable countdown that raises
// irq with a level/vector, with status readback, auto-reload, ack counting and overrun.
module jt900h_intctl #(
  parameter logic [22:0] BASE  = 23'h7ff8,
  parameter logic [2:0]  VBASE = 3'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [23:1] addr,
  input  logic [15:0] din,
  input  logic [1:0]  we,
  input  logic        rd,
  output logic [15:0] dout,
  output logic        irq,
  input  logic        irq_ack,
  output logic [2:0]  int_lvl,
  output logic [7:0]  int_addr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PEND  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  dly_reg, dly_next;
  logic        auto_reg, auto_next;
  logic [2:0]  lvl_reg, lvl_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        irq_reg, irq_next;
  logic [2:0]  int_lvl_reg, int_lvl_next;
  logic        ovr_reg, ovr_next;
  logic [7:0]  acks_reg, acks_next;

  logic        sel;
  logic [1:0]  idx;
  logic        wr_ctrl_hi, wr_ctrl_lo, wr_stat, wr_acks;
  logic        armed;
  logic [7:0]  acks_inc;

  assign sel   = (addr[23:3] == BASE[22:2]);
  assign idx   = addr[2:1];
  assign armed = (state_reg == COUNT);

  assign wr_ctrl_hi = sel && (idx == 2'd0) && we[1];
  assign wr_ctrl_lo = sel && (idx == 2'd0) && we[0];
  assign wr_stat    = sel && (idx == 2'd1) && (we != 2'b00);
  assign wr_acks    = sel && (idx == 2'd2) && (we != 2'b00);

  assign acks_inc = (acks_reg == 8'hff) ? acks_reg : acks_reg + 8'd1;

  always_comb begin
    state_next   = state_reg;
    dly_next     = dly_reg;
    auto_next    = auto_reg;
    lvl_next     = lvl_reg;
    cnt_next     = cnt_reg;
    irq_next     = irq_reg;
    int_lvl_next = int_lvl_reg;
    ovr_next     = ovr_reg;
    acks_next    = acks_reg;

    case (state_reg)
      COUNT: begin
        if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
        end else begin
          irq_next     = 1'b1;
          state_next   = PEND;
          int_lvl_next = lvl_reg;
          // Reload so the shadow countdown can detect a missed period while pending.
          if (auto_reg) cnt_next = dly_reg;
        end
      end
      PEND: begin
        if (irq_ack) begin
          irq_next  = 1'b0;
          acks_next = acks_inc;
          if (auto_reg) begin
            cnt_next   = dly_reg;
            state_next = COUNT;
          end else begin
            state_next = IDLE;
          end
        end else if (auto_reg) begin
          if (cnt_reg != 8'd0) begin
            cnt_next = cnt_reg - 8'd1;
          end else begin
            ovr_next = 1'b1;
            cnt_next = dly_reg;
          end
        end
      end
      default: ;
    endcase

    // Bus writes override the sequencer; an ack in the same cycle is still counted above.
    if (wr_ctrl_hi) dly_next = din[15:8];
    if (wr_ctrl_lo) begin
      auto_next  = din[7];
      lvl_next   = din[2:0];
      cnt_next   = we[1] ? din[15:8] : dly_reg;
      irq_next   = 1'b0;
      state_next = (din[2:0] != 3'd0) ? COUNT : IDLE;
    end
    if (wr_stat) ovr_next = 1'b0;
    if (wr_acks) acks_next = 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      dly_reg     <= 8'd0;
      auto_reg    <= 1'b0;
      lvl_reg     <= 3'd0;
      cnt_reg     <= 8'd0;
      irq_reg     <= 1'b0;
      int_lvl_reg <= 3'd0;
      ovr_reg     <= 1'b0;
      acks_reg    <= 8'd0;
    end else if (cen) begin
      state_reg   <= state_next;
      dly_reg     <= dly_next;
      auto_reg    <= auto_next;
      lvl_reg     <= lvl_next;
      cnt_reg     <= cnt_next;
      irq_reg     <= irq_next;
      int_lvl_reg <= int_lvl_next;
      ovr_reg     <= ovr_next;
      acks_reg    <= acks_next;
    end
  end

  always_comb begin
    dout = 16'd0;
    if (sel && rd) begin
      case (idx)
        2'd0:    dout = {dly_reg, auto_reg, 4'd0, lvl_reg};
        2'd1:    dout = {ovr_reg, irq_reg, armed, 5'd0, cnt_reg};
        2'd2:    dout = {8'd0, acks_reg};
        default: dout = 16'd0;
      endcase
    end
  end

  assign irq      = irq_reg;
  assign int_lvl  = int_lvl_reg;
  assign int_addr = {VBASE, int_lvl_reg, 2'b00};

endmodule

// File: tb/tb_jt900h_intctl.sv
// Directed bench for jt900h_intctl: register access, countdown timing, auto-reload,
// overrun, ack/write collision, clock enable and asynchronous reset.
module tb_jt900h_intctl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b1;
  logic [23:1] addr = 23'd0;
  logic [15:0] din = 16'd0;
  logic [1:0]  we = 2'b00;
  logic        rd = 1'b0;
  logic [15:0] dout;
  logic        irq;
  logic        irq_ack = 1'b0;
  logic [2:0]  int_lvl;
  logic [7:0]  int_addr;

  int passed = 0;
  int total  = 0;
  logic [15:0] rv;

  localparam logic [22:0] BASE = 23'h7ff8;

  jt900h_intctl dut (
    .clk(clk), .rst(rst), .cen(cen), .addr(addr), .din(din), .we(we), .rd(rd),
    .dout(dout), .irq(irq), .irq_ack(irq_ack), .int_lvl(int_lvl), .int_addr(int_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [15:0] data, input logic [1:0] wen);
    addr = BASE + {21'd0, idx};
    din  = data;
    we   = wen;
    tick(1);
    we   = 2'b00;
    $display("write R%0d = %h we=%b", idx, data, wen);
  endtask

  task automatic rdreg(input logic [1:0] idx, output logic [15:0] val);
    addr = BASE + {21'd0, idx};
    rd   = 1'b1;
    #1;
    val  = dout;
    rd   = 1'b0;
    $display("read  R%0d = %h", idx, val);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_irq", {15'd0, irq}, 16'd0);
    check("rst_lvl", {13'd0, int_lvl}, 16'd0);
    check("rst_addr", {8'd0, int_addr}, 16'h0020);
    rdreg(2'd0, rv); check("rst_r0", rv, 16'h0000);
    rdreg(2'd1, rv); check("rst_r1", rv, 16'h0000);
    rdreg(2'd2, rv); check("rst_r2", rv, 16'h0000);

    // 1: DLY=5, LVL=3 -> irq six cycles after the write
    wr(2'd0, 16'h0503, 2'b11);
    rdreg(2'd0, rv); check("t1_ctrl", rv, 16'h0503);
    rdreg(2'd1, rv); check("t1_armed", rv, 16'h2005);
    tick(5);
    check("t1_irq_early", {15'd0, irq}, 16'd0);
    tick(1);
    check("t1_irq", {15'd0, irq}, 16'd1);
    check("t1_lvl", {13'd0, int_lvl}, 16'd3);
    check("t1_vec", {8'd0, int_addr}, 16'h002c);
    rdreg(2'd1, rv); check("t1_stat_pend", rv, 16'h4000);

    // 2: acknowledge
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    check("t2_irq", {15'd0, irq}, 16'd0);
    rdreg(2'd2, rv); check("t2_acks", rv, 16'h0001);
    rdreg(2'd1, rv); check("t2_stat", rv, 16'h0000);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    rdreg(2'd2, rv); check("t2_ack_idle", rv, 16'h0001);
    wr(2'd3, 16'hffff, 2'b11);
    rdreg(2'd3, rv); check("r3_zero", rv, 16'h0000);

    // 3: auto reload DLY=3, LVL=2
    wr(2'd0, 16'h0382, 2'b11);
    tick(3);
    check("t3_irq_early", {15'd0, irq}, 16'd0);
    tick(1);
    check("t3_irq", {15'd0, irq}, 16'd1);
    check("t3_vec", {8'd0, int_addr}, 16'h0028);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    check("t3_ack_irq", {15'd0, irq}, 16'd0);
    tick(3);
    check("t3_reirq_early", {15'd0, irq}, 16'd0);
    tick(1);
    check("t3_reirq", {15'd0, irq}, 16'd1);
    tick(3);
    rdreg(2'd1, rv); check("t3_no_ovr", rv, 16'h4000);
    tick(1);
    rdreg(2'd1, rv); check("t3_ovr", rv, 16'hc003);
    rdreg(2'd2, rv); check("t3_acks", rv, 16'h0002);
    wr(2'd1, 16'h0000, 2'b11);
    rdreg(2'd1, rv); check("t3_ovr_clr", rv, 16'h4002);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    rdreg(2'd2, rv); check("t3_acks3", rv, 16'h0003);
    wr(2'd0, 16'h0000, 2'b11);
    wr(2'd2, 16'h0000, 2'b01);
    rdreg(2'd2, rv); check("t3_acks_clr", rv, 16'h0000);

    // 4: cancel mid-count, then DLY=0
    wr(2'd0, 16'h1001, 2'b11);
    tick(3);
    wr(2'd0, 16'h0000, 2'b11);
    tick(20);
    check("t4_no_irq", {15'd0, irq}, 16'd0);
    rdreg(2'd1, rv); check("t4_stat", rv, 16'h0000);
    wr(2'd0, 16'h0001, 2'b11);
    check("t4_irq_wait", {15'd0, irq}, 16'd0);
    tick(1);
    check("t4_irq", {15'd0, irq}, 16'd1);
    check("t4_vec", {8'd0, int_addr}, 16'h0024);

    // 6: R0 write and ack in the same cycle while pending
    irq_ack = 1'b1;
    wr(2'd0, 16'h0401, 2'b11);
    irq_ack = 1'b0;
    check("t6_irq", {15'd0, irq}, 16'd0);
    rdreg(2'd2, rv); check("t6_acks", rv, 16'h0001);
    rdreg(2'd1, rv); check("t6_rearm", rv, 16'h2004);
    tick(4);
    check("t6_irq_early", {15'd0, irq}, 16'd0);
    tick(1);
    check("t6_irq_again", {15'd0, irq}, 16'd1);
    wr(2'd0, 16'h0000, 2'b11);

    // 5: cen every other clock, DLY=2, LVL=4
    wr(2'd0, 16'h0204, 2'b11);
    cen = 1'b0; tick(1); cen = 1'b1; tick(1);
    cen = 1'b0; tick(1); cen = 1'b1; tick(1);
    cen = 1'b0; tick(1);
    check("t5_irq_early", {15'd0, irq}, 16'd0);
    cen = 1'b1; tick(1);
    check("t5_irq", {15'd0, irq}, 16'd1);
    check("t5_vec", {8'd0, int_addr}, 16'h0030);
    cen = 1'b0; irq_ack = 1'b1; tick(2); irq_ack = 1'b0;
    check("t5_hold", {15'd0, irq}, 16'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_irq", {15'd0, irq}, 16'd0);
    check("t5_rst_vec", {8'd0, int_addr}, 16'h0020);
    rdreg(2'd0, rv); check("t5_rst_r0", rv, 16'h0000);
    rdreg(2'd1, rv); check("t5_rst_r1", rv, 16'h0000);
    rdreg(2'd2, rv); check("t5_rst_r2", rv, 16'h0000);
    rst = 1'b0;
    cen = 1'b1;
    tick(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
